// File: rtl/crc_engine.sv
// Parametrised multi-cycle CRC generator/checker: accepts one DATA_W-bit word per
// enable handshake and folds BITS_PER_CLK bits per clock into a running CRC.
module crc_engine #(
    parameter int               CRC_W        = 8,
    parameter logic [CRC_W-1:0] POLY         = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] INIT         = '0,
    parameter logic [CRC_W-1:0] XOROUT       = '0,
    parameter bit               REFIN        = 1'b0,
    parameter bit               REFOUT       = 1'b0,
    parameter logic [CRC_W-1:0] RESIDUE      = '0,
    parameter int               DATA_W       = 8,
    parameter int               BITS_PER_CLK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic              enable,
    input  logic              clr,
    output logic              ready,
    output logic [CRC_W-1:0]  out,
    output logic              complete,
    output logic              match,
    output logic              drop
);

    localparam int N     = DATA_W / BITS_PER_CLK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] x);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) r[i] = x[CRC_W-1-i];
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] x);
        return (REFOUT ? rev_crc(x) : x) ^ XOROUT;
    endfunction

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic [CRC_W-1:0]   crc_reg, crc_next;
    logic [CRC_W-1:0]   out_reg, out_next;
    logic               complete_reg, complete_next;
    logic               match_reg, match_next;
    logic               drop_reg, drop_next;
    logic [DATA_W-1:0]  in_refl;
    logic [CRC_W-1:0]   crc_step;
    logic               fb;
    logic               last_step;

    // Reflected input is loaded so the shift register always feeds MSB first.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_refin
            assign in_refl[gi] = REFIN ? in[DATA_W-1-gi] : in[gi];
        end
    endgenerate

    always_comb begin
        crc_step = crc_reg;
        fb       = 1'b0;
        for (int i = 0; i < BITS_PER_CLK; i++) begin
            fb       = crc_step[CRC_W-1] ^ shift_reg[DATA_W-1-i];
            crc_step = (crc_step << 1) ^ ({CRC_W{fb}} & POLY);
        end
    end

    assign last_step = (cnt_reg == LAST_STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            crc_reg      <= INIT;
            out_reg      <= finalize(INIT);
            complete_reg <= 1'b0;
            match_reg    <= (INIT == RESIDUE);
            drop_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shift_reg    <= shift_next;
            crc_reg      <= crc_next;
            out_reg      <= out_next;
            complete_reg <= complete_next;
            match_reg    <= match_next;
            drop_reg     <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        crc_next   = crc_reg;
        if (clr) begin
            state_next = IDLE;
            cnt_next   = '0;
            crc_next   = INIT;
        end else if (state_reg == IDLE) begin
            if (enable) begin
                state_next = BUSY;
                cnt_next   = '0;
                shift_next = in_refl;
            end
        end else begin
            crc_next   = crc_step;
            shift_next = shift_reg << BITS_PER_CLK;
            cnt_next   = cnt_reg + CNT_W'(1);
            if (last_step) begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end
    end

    // out/match only move on a finished word or a restart, so they hold mid-word.
    always_comb begin
        out_next      = out_reg;
        match_next    = match_reg;
        complete_next = 1'b0;
        drop_next     = 1'b0;
        if (clr) begin
            out_next   = finalize(INIT);
            match_next = (INIT == RESIDUE);
        end else if (state_reg == BUSY) begin
            drop_next = enable;
            if (last_step) begin
                complete_next = 1'b1;
                out_next      = finalize(crc_step);
                match_next    = (crc_step == RESIDUE);
            end
        end
    end

    assign ready    = (state_reg == IDLE);
    assign out      = out_reg;
    assign complete = complete_reg;
    assign match    = match_reg;
    assign drop     = drop_reg;

endmodule
